// File: rtl/sprite_bus_pkg.sv
// Shared definitions for the sprite ROM bus: requester ids, default widths
// and the read-return tag that travels alongside each ROM access.
package sprite_bus_pkg;

  localparam int REQ_FIREBOY  = 0;
  localparam int REQ_ICEGIRL  = 1;
  localparam int REQ_ELEVATOR = 2;
  localparam int REQ_SCORE    = 3;

  localparam int SPRITE_ADDR_W = 16;
  localparam int SPRITE_DATA_W = 8;

  localparam int TAG_ID_W    = 3;
  localparam int BURST_CNT_W = 4;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or after i_start
// (wrapping modulo N) that is not masked by i_excl.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  input  logic [N-1:0]     i_excl,
  output logic [N-1:0]     o_onehot,
  output logic             o_found
);

  logic [N-1:0] w_cand;

  assign w_cand = i_req & ~i_excl;

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    int j;
    o_onehot = '0;
    o_found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_start) + k;
      if (j >= N) j = j - N;
      if (!o_found && w_cand[j]) begin
        o_onehot[j] = 1'b1;
        o_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// One-read-per-cycle arbiter for the shared sprite ROM with burst limiting
// and an in-order tag pipeline that routes returned data to its requester.
module sprite_rom_arbiter
  import sprite_bus_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = SPRITE_ADDR_W,
  parameter int DATA_W    = SPRITE_DATA_W,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic                    rom_rd,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy
);

  localparam int                     IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_BURST);

  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       r_owner;
  logic [BURST_CNT_W-1:0] r_burst_cnt;
  rd_tag_t                r_tag [RD_LAT];

  logic [N_REQ-1:0]       w_owner_oh;
  logic [N_REQ-1:0]       w_excl;
  logic [N_REQ-1:0]       w_win_oh;
  logic                   w_found;
  logic                   w_burst_live;
  logic                   w_hold;
  logic                   w_capped;
  logic [IDX_W-1:0]       w_start;
  logic [IDX_W-1:0]       w_win_idx;
  logic [IDX_W-1:0]       w_next_ptr;
  logic [BURST_CNT_W-1:0] w_next_cnt;
  rd_tag_t                w_ret;

  always_comb begin
    w_owner_oh = '0;
    for (int i = 0; i < N_REQ; i++) w_owner_oh[i] = (r_owner == IDX_W'(i));
  end

  // A nonzero count means the owner was granted last cycle.
  assign w_burst_live = (r_burst_cnt != '0) && (r_burst_cnt < BURST_MAX);
  assign w_hold       = |(req & w_owner_oh) && w_burst_live;
  assign w_capped     = (r_burst_cnt == BURST_MAX) && |(req & ~w_owner_oh);

  // After any grant ptr already equals owner+1, so a capped scan starts there.
  assign w_start = w_hold ? r_owner : r_ptr;
  assign w_excl  = w_capped ? w_owner_oh : '0;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req    (req),
    .i_start  (w_start),
    .i_excl   (w_excl),
    .o_onehot (w_win_oh),
    .o_found  (w_found)
  );

  always_comb begin
    w_win_idx = '0;
    rom_addr  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win_oh[i]) begin
        w_win_idx = IDX_W'(i);
        rom_addr  = addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign gnt    = w_win_oh;
  assign rom_rd = w_found;

  assign w_next_ptr = (w_win_idx == LAST_IDX) ? '0 : w_win_idx + IDX_W'(1);
  // An owner that hits the cap with nobody else waiting restarts its burst at 1.
  assign w_next_cnt = ((w_win_idx == r_owner) && w_burst_live)
                    ? r_burst_cnt + BURST_CNT_W'(1)
                    : BURST_CNT_W'(1);

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values and the tag shift does not collapse in one cycle.
  // NOTE: the tag pipeline is reset, unlike a data memory, because a stale
  // valid bit would deliver data for a read the requester no longer expects.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      for (int k = 0; k < RD_LAT; k++) r_tag[k] <= '0;
    end else begin
      if (w_found) begin
        r_owner     <= w_win_idx;
        r_ptr       <= w_next_ptr;
        r_burst_cnt <= w_next_cnt;
      end else begin
        r_burst_cnt <= '0;
      end
      r_tag[0].valid <= w_found;
      r_tag[0].id    <= TAG_ID_W'(w_win_idx);
      for (int k = 1; k < RD_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign w_ret = r_tag[RD_LAT-1];
  assign rdata = rom_q;

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < N_REQ; i++) rvalid[i] = w_ret.valid && (w_ret.id == TAG_ID_W'(i));
  end

  always_comb begin
    busy = rom_rd;
    for (int k = 0; k < RD_LAT; k++) busy = busy | r_tag[k].valid;
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: three configurations checked every cycle
// against a behavioural arbitration model, plus directed literal scenarios.
module tb_sprite_rom_arbiter;
  import sprite_bus_pkg::*;

  localparam int NI = 3;
  localparam int NR [NI] = '{4, 4, 3};
  localparam int LT [NI] = '{2, 2, 4};
  localparam int MB [NI] = '{4, 1, 4};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  t_req  [NI];
  logic [63:0] t_addr [NI];

  logic [3:0]  a_gnt, b_gnt, a_rv, b_rv;
  logic [2:0]  c_gnt, c_rv;
  logic [15:0] a_ra, b_ra, c_ra;
  logic        a_rd, b_rd, c_rd, a_busy, b_busy, c_busy;
  logic [7:0]  a_q, b_q, c_q, a_rdata, b_rdata, c_rdata;

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(8), .RD_LAT(2), .MAX_BURST(4)) u_a (
    .Clk(clk), .Reset(rst), .req(t_req[0]), .addr(t_addr[0]), .gnt(a_gnt),
    .rom_addr(a_ra), .rom_rd(a_rd), .rom_q(a_q), .rvalid(a_rv), .rdata(a_rdata), .busy(a_busy));

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(8), .RD_LAT(2), .MAX_BURST(1)) u_b (
    .Clk(clk), .Reset(rst), .req(t_req[1]), .addr(t_addr[1]), .gnt(b_gnt),
    .rom_addr(b_ra), .rom_rd(b_rd), .rom_q(b_q), .rvalid(b_rv), .rdata(b_rdata), .busy(b_busy));

  sprite_rom_arbiter #(.N_REQ(3), .ADDR_W(16), .DATA_W(8), .RD_LAT(4), .MAX_BURST(4)) u_c (
    .Clk(clk), .Reset(rst), .req(t_req[2][2:0]), .addr(t_addr[2][47:0]), .gnt(c_gnt),
    .rom_addr(c_ra), .rom_rd(c_rd), .rom_q(c_q), .rvalid(c_rv), .rdata(c_rdata), .busy(c_busy));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit m_known = 1'b0;

  // Model state: arbitration pointers, current run length, issue history.
  int          m_ptr [NI];
  int          m_owner [NI];
  int          m_run [NI];
  int          m_last_w [NI];
  int          m_iss_id [NI][4];
  logic [15:0] m_iss_addr [NI][4];
  logic [15:0] rom_hist [NI][4];

  logic [3:0]  lg_gnt [NI];
  logic [3:0]  lg_rv [NI];
  logic [15:0] lg_addr [NI];
  logic [7:0]  lg_rdata [NI];
  logic        lg_rd [NI];
  logic        lg_busy [NI];

  logic [3:0] exp3 [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001};
  logic [3:0] seq6 [8] = '{4'b0100, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] rv6  [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0010, 4'b0000};

  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  // Winner from the arbitration rules: burst hold, cap exclusion, rotating scan.
  function automatic int m_pick(input int k, input logic [3:0] r);
    int n;
    logic [3:0] cand;
    n = NR[k];
    if (r == 4'b0) return -1;
    if (m_run[k] > 0 && m_run[k] < MB[k] && r[m_owner[k]]) return m_owner[k];
    cand = r;
    if (m_run[k] == MB[k] && (r & ~(4'b1 << m_owner[k])) != 4'b0) cand[m_owner[k]] = 1'b0;
    for (int off = 0; off < n; off++)
      if (cand[(m_ptr[k] + off) % n]) return (m_ptr[k] + off) % n;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_ptr[k] = 0; m_owner[k] = 0; m_run[k] = 0;
      for (int d = 0; d < 4; d++) m_iss_id[k][d] = -1;
    end
  endtask

  task automatic tick();
    int w [NI];
    int rid;
    logic [3:0]  eg;
    logic [15:0] ea [NI];
    logic        eb;
    a_q = rom_f(rom_hist[0][LT[0]-1]);
    b_q = rom_f(rom_hist[1][LT[1]-1]);
    c_q = rom_f(rom_hist[2][LT[2]-1]);
    #1;
    lg_gnt[0] = a_gnt;  lg_gnt[1] = b_gnt;  lg_gnt[2] = {1'b0, c_gnt};
    lg_rv[0]  = a_rv;   lg_rv[1]  = b_rv;   lg_rv[2]  = {1'b0, c_rv};
    lg_addr[0] = a_ra;  lg_addr[1] = b_ra;  lg_addr[2] = c_ra;
    lg_rdata[0] = a_rdata; lg_rdata[1] = b_rdata; lg_rdata[2] = c_rdata;
    lg_rd[0] = a_rd;    lg_rd[1] = b_rd;    lg_rd[2] = c_rd;
    lg_busy[0] = a_busy; lg_busy[1] = b_busy; lg_busy[2] = c_busy;
    for (int k = 0; k < NI; k++) begin
      w[k]  = m_pick(k, t_req[k]);
      eg    = (w[k] >= 0) ? (4'b1 << w[k]) : 4'b0;
      ea[k] = (w[k] >= 0) ? t_addr[k][w[k]*16 +: 16] : 16'h0;
      rid   = m_iss_id[k][LT[k]-1];
      eb    = (w[k] >= 0);
      for (int d = 0; d < LT[k]; d++) if (m_iss_id[k][d] >= 0) eb = 1'b1;
      if (m_known) begin
        check("gnt", k, 32'(lg_gnt[k]), 32'(eg));
        check("rom_rd", k, 32'(lg_rd[k]), 32'(w[k] >= 0));
        check("rom_addr", k, 32'(lg_addr[k]), 32'(ea[k]));
        check("rvalid", k, 32'(lg_rv[k]), (rid >= 0) ? (32'd1 << rid) : 32'd0);
        if (rid >= 0) check("rdata", k, 32'(lg_rdata[k]), 32'(rom_f(m_iss_addr[k][LT[k]-1])));
        check("busy", k, 32'(lg_busy[k]), 32'(eb));
      end
    end
    for (int k = 0; k < NI; k++) begin
      for (int d = 3; d > 0; d--) begin
        rom_hist[k][d]   = rom_hist[k][d-1];
        m_iss_id[k][d]   = m_iss_id[k][d-1];
        m_iss_addr[k][d] = m_iss_addr[k][d-1];
      end
      rom_hist[k][0]   = lg_addr[k];
      m_iss_id[k][0]   = w[k];
      m_iss_addr[k][0] = ea[k];
      if (w[k] >= 0) begin
        if (w[k] == m_owner[k] && m_run[k] > 0) m_run[k] = (m_run[k] == MB[k]) ? 1 : m_run[k] + 1;
        else m_run[k] = 1;
        m_owner[k] = w[k];
        m_ptr[k]   = (w[k] + 1) % NR[k];
      end else begin
        m_run[k] = 0;
      end
      m_last_w[k] = w[k];
    end
    if (rst) begin
      model_reset();
      m_known = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int k = 0; k < NI; k++) t_req[k] = 4'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic gen();
    rst = ($urandom_range(199) == 0);
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < NR[k]; i++) begin
        if (t_req[k][i] && m_last_w[k] == i) begin
          t_req[k][i] = ($urandom_range(3) != 0);
          t_addr[k][i*16 +: 16] = 16'($urandom);
        end else if (t_req[k][i]) begin
          if ($urandom_range(15) == 0) t_req[k][i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          t_req[k][i] = 1'b1;
          t_addr[k][i*16 +: 16] = 16'($urandom);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      t_req[k] = 4'b0; t_addr[k] = 64'h0; m_last_w[k] = -1;
      for (int d = 0; d < 4; d++) begin rom_hist[k][d] = 16'h0; m_iss_addr[k][d] = 16'h0; end
    end
    a_q = 8'h0; b_q = 8'h0; c_q = 8'h0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    // Reset state with no requests.
    tick();
    check("rst_gnt", 0, 32'(lg_gnt[0]), 32'h0);
    check("rst_rvalid", 0, 32'(lg_rv[0]), 32'h0);
    check("rst_rom_rd", 0, 32'(lg_rd[0]), 32'h0);
    check("rst_busy", 0, 32'(lg_busy[0]), 32'h0);
    check("rst_rom_addr", 0, 32'(lg_addr[0]), 32'h0);

    // Single requester, latency 2.
    t_req[0] = 4'b0010; t_addr[0][31:16] = 16'h1234;
    tick();
    check("single_gnt", 0, 32'(lg_gnt[0]), 32'h2);
    check("single_addr", 0, 32'(lg_addr[0]), 32'h1234);
    t_req[0] = 4'b0;
    tick();
    tick();
    check("single_rvalid", 0, 32'(lg_rv[0]), 32'h2);
    check("single_rdata", 0, 32'(lg_rdata[0]), 32'h83);
    tick();
    check("single_busy_low", 0, 32'(lg_busy[0]), 32'h0);

    // All four requesting with MAX_BURST=1: strict rotation.
    do_reset();
    t_req[1] = 4'b1111; t_addr[1] = 64'h0300_0200_0100_0000;
    for (int j = 0; j < 7; j++) begin
      tick();
      if (j < 5) check("rot_gnt", 1, 32'(lg_gnt[1]), 32'd1 << (j % 4));
      if (j >= 2) check("rot_rvalid", 1, 32'(lg_rv[1]), 32'd1 << ((j - 2) % 4));
    end
    t_req[1] = 4'b0;
    tick(); tick(); tick();

    // Burst cap: req0 held, req2 waits four grants.
    do_reset();
    t_req[0] = 4'b0101; t_addr[0] = 64'h0000_2222_0000_1111;
    for (int j = 0; j < 6; j++) begin
      tick();
      check("burst_gnt", 0, 32'(lg_gnt[0]), 32'(exp3[j]));
      if (lg_gnt[0][2]) t_req[0][2] = 1'b0;
    end
    t_req[0] = 4'b0;
    tick(); tick(); tick();

    // Req3 pulsed for one cycle while req1 holds a burst.
    t_req[0] = 4'b0010; t_addr[0] = 64'h4444_0000_5555_0000;
    tick();
    t_req[0] = 4'b1010;
    tick();
    check("pulse_gnt", 0, 32'(lg_gnt[0]), 32'h2);
    t_req[0] = 4'b0010;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("pulse_no_rv3", 0, 32'(lg_rv[0][3]), 32'h0);
    end
    t_req[0] = 4'b0;
    tick(); tick(); tick();

    // Reset with reads in flight.
    t_req[0] = 4'b0001; t_addr[0] = 64'h3333_0000_0000_0A0A;
    tick();
    check("mid_gnt_t", 0, 32'(lg_gnt[0]), 32'h1);
    rst = 1'b1;
    tick();
    check("mid_gnt_t1", 0, 32'(lg_gnt[0]), 32'h1);
    rst = 1'b0; t_req[0] = 4'b0;
    tick();
    check("mid_rv_t2", 0, 32'(lg_rv[0]), 32'h0);
    t_req[0] = 4'b1001;
    tick();
    check("mid_rv_t3", 0, 32'(lg_rv[0]), 32'h0);
    check("mid_gnt_t3", 0, 32'(lg_gnt[0]), 32'h1);
    t_req[0] = 4'b1000;
    tick();
    check("mid_rv_t4", 0, 32'(lg_rv[0]), 32'h0);
    check("mid_gnt_t4", 0, 32'(lg_gnt[0]), 32'h8);
    t_req[0] = 4'b0;
    tick();
    check("mid_rv_t5", 0, 32'(lg_rv[0]), 32'h1);
    tick();
    check("mid_rv_t6", 0, 32'(lg_rv[0]), 32'h8);

    // N_REQ=3, RD_LAT=4: ids 2,0,1 back to back.
    do_reset();
    t_addr[2] = 64'h0000_0C0C_0B0B_0A0A;
    for (int j = 0; j < 8; j++) begin
      t_req[2] = seq6[j];
      tick();
      if (j < 4) check("lat4_gnt", 2, 32'(lg_gnt[2]), 32'(seq6[j]));
      check("lat4_rvalid", 2, 32'(lg_rv[2]), 32'(rv6[j]));
      check("lat4_busy", 2, 32'(lg_busy[2]), (j < 7) ? 32'h1 : 32'h0);
    end

    // Randomised traffic on all three configurations.
    for (int j = 0; j < 1500; j++) begin
      gen();
      tick();
    end
    rst = 1'b0;
    for (int k = 0; k < NI; k++) t_req[k] = 4'b0;
    for (int j = 0; j < 6; j++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
